// File: rtl/iro_ctrl.sv
// Sequencer for one instrumented ring oscillator: loads the seed serially,
// runs the ring for a programmed number of clocks, freezes it and captures
// the phase taps twice to flag an unstable capture.
module iro_ctrl #(
    parameter int unsigned N_STAGES = 25,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned RUN_W    = 16,
    parameter int unsigned SETTLE   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_STAGES-1:0] seed_in,
    input  logic [3:0]          stages_in,
    input  logic [RUN_W-1:0]    run_cycles,
    output logic                busy,
    output logic                done,
    output logic [15:0]         result,
    output logic                result_stable,
    output logic                iro_enable,
    output logic                iro_hold,
    output logic                iro_bclk,
    output logic                iro_bdat,
    output logic [3:0]          iro_n_stages,
    input  logic [15:0]         iro_phases
);

    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
    localparam int unsigned BIT_W = $clog2(N_STAGES);
    localparam int unsigned HLD_W = $clog2(SETTLE + 2);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StRun,
        StHold,
        StCapture,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [HLD_W-1:0]    hcnt_q, hcnt_d;
    logic [N_STAGES-1:0] sreg_q, sreg_d;
    logic [3:0]          nst_q, nst_d;
    logic [15:0]         s1_q, s2_q;
    logic [15:0]         a_q, a_d;
    logic [15:0]         result_q, result_d;
    logic                stable_q, stable_d;
    // IRO pins are registered so the asynchronous ring never sees glitches;
    // they follow the state by one cycle.
    logic                en_q, en_d;
    logic                hold_q, hold_d;
    logic                bclk_q, bclk_d;
    logic                bdat_q, bdat_d;

    // Two-flop synchronizer for the asynchronous phase taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= iro_phases;
            s2_q <= s1_q;
        end
    end

    // Next-state, counter and pin logic.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        run_d    = run_q;
        hcnt_d   = hcnt_q;
        sreg_d   = sreg_q;
        nst_d    = nst_q;
        a_d      = a_q;
        result_d = result_q;
        stable_d = stable_q;
        en_d     = 1'b0;
        hold_d   = 1'b0;
        bclk_d   = 1'b0;
        bdat_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sreg_d  = seed_in;
                    run_d   = (run_cycles == '0) ? RUN_W'(1) : run_cycles;
                    nst_d   = stages_in;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                bclk_d = (div_q >= DIV_W'(CLK_DIV));
                bdat_d = sreg_q[N_STAGES-1];
                if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
                    div_d  = '0;
                    sreg_d = sreg_q << 1;
                    if (bit_q == BIT_W'(N_STAGES - 1)) begin
                        bit_d   = '0;
                        state_d = StRun;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StRun: begin
                en_d = 1'b1;
                if (run_q == RUN_W'(1)) begin
                    hcnt_d  = '0;
                    state_d = StHold;
                end else begin
                    run_d = run_q - RUN_W'(1);
                end
            end
            StHold: begin
                en_d   = 1'b1;
                hold_d = 1'b1;
                if (hcnt_q == HLD_W'(SETTLE + 1)) begin
                    a_d     = s2_q;
                    state_d = StCapture;
                end else begin
                    hcnt_d = hcnt_q + HLD_W'(1);
                end
            end
            StCapture: begin
                result_d = s2_q;
                stable_d = (a_q == s2_q);
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Abort only applies while busy; it keeps the previous result.
        if (abort && (state_q != StIdle)) begin
            state_d  = StIdle;
            en_d     = 1'b0;
            hold_d   = 1'b0;
            bclk_d   = 1'b0;
            bdat_d   = 1'b0;
            result_d = result_q;
            stable_d = stable_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bit_q    <= '0;
            run_q    <= '0;
            hcnt_q   <= '0;
            sreg_q   <= '0;
            nst_q    <= '0;
            a_q      <= '0;
            result_q <= '0;
            stable_q <= 1'b0;
            en_q     <= 1'b0;
            hold_q   <= 1'b0;
            bclk_q   <= 1'b0;
            bdat_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            run_q    <= run_d;
            hcnt_q   <= hcnt_d;
            sreg_q   <= sreg_d;
            nst_q    <= nst_d;
            a_q      <= a_d;
            result_q <= result_d;
            stable_q <= stable_d;
            en_q     <= en_d;
            hold_q   <= hold_d;
            bclk_q   <= bclk_d;
            bdat_q   <= bdat_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign result        = result_q;
    assign result_stable = stable_q;
    assign iro_enable    = en_q;
    assign iro_hold      = hold_q;
    assign iro_bclk      = bclk_q;
    assign iro_bdat      = bdat_q;
    assign iro_n_stages  = nst_q;

endmodule

// File: tb/tb_iro_ctrl.sv
// Self-checking bench for iro_ctrl: table vectors, randomized measurements
// against a timing/protocol model, plus abort and reset corner cases.
module tb_iro_ctrl;

    localparam int N = 25;
    localparam int D = 2;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [24:0] seed_in;
    logic [3:0]  stages_in;
    logic [15:0] run_cycles;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        result_stable;
    logic        iro_enable;
    logic        iro_hold;
    logic        iro_bclk;
    logic        iro_bdat;
    logic [3:0]  iro_n_stages;
    logic [15:0] iro_phases;

    iro_ctrl #(
        .N_STAGES (N),
        .CLK_DIV  (D),
        .RUN_W    (16),
        .SETTLE   (S)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .seed_in       (seed_in),
        .stages_in     (stages_in),
        .run_cycles    (run_cycles),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .result_stable (result_stable),
        .iro_enable    (iro_enable),
        .iro_hold      (iro_hold),
        .iro_bclk      (iro_bclk),
        .iro_bdat      (iro_bdat),
        .iro_n_stages  (iro_n_stages),
        .iro_phases    (iro_phases)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] seed;
        logic [3:0]  stg;
        int          run;
        logic [15:0] ph;
        bit          tog;
        int          mid;   // sample index at which a stray start is pulsed, -1 none
        int          busy;
        int          en;
        logic [15:0] res;
        bit          stab;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] last_res = '0;
    bit          last_stab = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference timing: a measurement is busy for the serial load, the run,
    // the hold window and one cycle each for capture and done.
    function automatic int model_en(input int run);
        return (run == 0) ? 1 : run;
    endfunction

    function automatic int model_busy(input int run);
        return 2 * D * N + model_en(run) + (S + 2) + 2;
    endfunction

    task automatic measure(input vec_t v, output int busy_n, output int edges,
                           output int en_n, output int hold_n, output int done_n,
                           output int bad, output logic [24:0] seen, output bit to);
        int   k;
        logic prev;
        logic last_bdat;
        busy_n = 0; edges = 0; en_n = 0; hold_n = 0; done_n = 0; bad = 0;
        seen = '0; to = 1'b0; k = 0; prev = 1'b0; last_bdat = 1'b0;
        @(negedge clk);
        seed_in    = v.seed;
        stages_in  = v.stg;
        run_cycles = 16'(v.run);
        iro_phases = v.ph;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (busy && !to) begin
            busy_n++;
            if (iro_bclk && !prev) begin
                edges++;
                seen      = {seen[23:0], iro_bdat};
                last_bdat = iro_bdat;
            end else if (iro_bclk && (iro_bdat !== last_bdat)) begin
                bad++;
            end
            prev = iro_bclk;
            if (iro_enable && !iro_hold) en_n++;
            if (iro_enable && iro_hold) hold_n++;
            if (done) done_n++;
            start = (k == v.mid);
            if (v.tog) iro_phases = ~iro_phases;
            k++;
            if (k > 5000) to = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_check(input string nm, input vec_t v);
        int          b, e, en, h, dn, bad;
        logic [24:0] seen;
        bit          to;
        measure(v, b, e, en, h, dn, bad, seen, to);
        chk({nm, "_timeout"}, 32'(to), 32'd0);
        chk({nm, "_edges"}, 32'(e), 32'(N));
        chk({nm, "_seed"}, 32'(seen), 32'(v.seed));
        chk({nm, "_bdat_stable"}, 32'(bad), 32'd0);
        chk({nm, "_busy_len"}, 32'(b), 32'(v.busy));
        chk({nm, "_run_len"}, 32'(en), 32'(v.en));
        chk({nm, "_hold_len"}, 32'(h), 32'(S + 2));
        chk({nm, "_done"}, 32'(dn), 32'd1);
        if (!v.tog) chk({nm, "_result"}, 32'(result), 32'(v.res));
        chk({nm, "_stable"}, 32'(result_stable), 32'(v.stab));
        chk({nm, "_n_stages"}, 32'(iro_n_stages), 32'(v.stg));
        repeat (5) @(negedge clk);
        chk({nm, "_idle_after"}, 32'(busy), 32'd0);
        if (!v.tog) last_res = v.res;
        last_stab = v.stab;
    endtask

    vec_t tbl[5];

    initial begin
        vec_t v;
        int   cnt;
        int   k;
        logic prev;

        tbl[0] = '{seed: 25'h1A5_5A5A, stg: 4'h9, run: 10, ph: 16'hBEEF, tog: 1'b0,
                   mid: 104, busy: 118, en: 10, res: 16'hBEEF, stab: 1'b1};
        tbl[1] = '{seed: 25'h1A5_5A5A, stg: 4'h3, run: 10, ph: 16'h1234, tog: 1'b0,
                   mid: 117, busy: 118, en: 10, res: 16'h1234, stab: 1'b1};
        tbl[2] = '{seed: 25'h000_0001, stg: 4'h0, run: 0, ph: 16'h0F0F, tog: 1'b0,
                   mid: -1, busy: 109, en: 1, res: 16'h0F0F, stab: 1'b1};
        tbl[3] = '{seed: 25'h0AA_5555, stg: 4'h7, run: 5, ph: 16'h0000, tog: 1'b1,
                   mid: -1, busy: 113, en: 5, res: 16'h0000, stab: 1'b0};
        tbl[4] = '{seed: 25'h1FF_FFFF, stg: 4'hF, run: 3, ph: 16'hA5C3, tog: 1'b0,
                   mid: -1, busy: 111, en: 3, res: 16'hA5C3, stab: 1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_in = '0; stages_in = '0;
        run_cycles = '0; iro_phases = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({busy, done, result_stable, iro_enable, iro_hold,
                             iro_bclk, iro_bdat}), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_n_stages", 32'(iro_n_stages), 32'd0);
        rst_n = 1'b1;

        // Idle with an abort pulse thrown in: nothing should start.
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            abort = (i == 20);
            @(negedge clk);
            if (busy) cnt++;
        end
        abort = 1'b0;
        chk("idle_busy", 32'(cnt), 32'd0);

        for (int i = 0; i < 5; i++) run_check($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 6; i++) begin
            v.seed = 25'($urandom());
            v.stg  = 4'($urandom_range(0, 15));
            v.run  = int'($urandom_range(0, 40));
            v.ph   = 16'($urandom());
            v.tog  = 1'b0;
            v.mid  = int'($urandom_range(0, 90));   // stray start during shift
            v.busy = model_busy(v.run);
            v.en   = model_en(v.run);
            v.res  = v.ph;
            v.stab = 1'b1;
            run_check($sformatf("rnd%0d", i), v);
        end

        // Abort during the serial load at bit 12.
        @(negedge clk);
        seed_in = 25'h155_AAAA; stages_in = 4'h5; run_cycles = 16'd20;
        iro_phases = 16'h7777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; cnt = 0; prev = 1'b0;
        while (cnt < 13 && k < 2000) begin
            if (iro_bclk && !prev) cnt++;
            prev = iro_bclk;
            k++;
            @(negedge clk);
        end
        chk("abort_reach_bit12", 32'(cnt), 32'd13);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pins", 32'({iro_bclk, iro_bdat, iro_enable, iro_hold, done}), 32'd0);
        chk("abort_result", 32'(result), 32'(last_res));
        chk("abort_stable", 32'(result_stable), 32'(last_stab));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("abort_quiet", 32'(cnt), 32'd0);
        v = tbl[0];
        v.mid = -1;
        v.ph  = 16'h5A5A;
        v.res = 16'h5A5A;
        run_check("after_abort", v);

        // start and abort together in idle: start wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_beats_abort", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_shift", 32'(busy), 32'd0);

        // Reset in the middle of the run.
        @(negedge clk);
        run_cycles = 16'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!iro_enable && k < 2000) begin
            k++;
            @(negedge clk);
        end
        chk("reach_run", 32'(iro_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_enable", 32'(iro_enable), 32'd0);
        chk("rst_run_busy", 32'(busy), 32'd0);
        chk("rst_run_result", 32'(result), 32'd0);
        chk("rst_run_n_stages", 32'(iro_n_stages), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_run_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
